// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: radix-2 iterative MULT/MULTU/DIV/DIVU, one bit per cycle,
// owns the HI/LO pair and freezes the pipeline through stall_req while an op is in flight.
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  flush,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_1,
  input  logic [DATA_WIDTH-1:0] operand_2,
  output logic                  stall_req,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_MTHI = 6'h11, F_MTLO = 6'h13;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    a_q, a_d;
  logic            neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;

  logic            is_mul, is_div, is_sgn, op1_neg, op2_neg, last;
  logic [W-1:0]    op1_abs, op2_abs;
  logic [W:0]      mul_sum, div_part;
  logic [W+1:0]    div_diff;
  logic [2*W-1:0]  mul_nxt, div_nxt, prod;
  logic [W-1:0]    quo, rem;

  always_comb begin
    is_mul  = (funct == F_MULT) || (funct == F_MULTU);
    is_div  = (funct == F_DIV)  || (funct == F_DIVU);
    is_sgn  = (funct == F_MULT) || (funct == F_DIV);
    op1_neg = is_sgn & operand_1[W-1];
    op2_neg = is_sgn & operand_2[W-1];
    op1_abs = op1_neg ? (W'(0) - operand_1) : operand_1;
    op2_abs = op2_neg ? (W'(0) - operand_2) : operand_2;
    last    = (cnt_q == CW'(W-1));
  end

  // One iteration of each engine. acc holds {partial, shifting operand} for both.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_nxt  = {mul_sum, acc_q[W-1:1]};
    // The shifted partial remainder can reach W+1 bits before the trial subtract.
    div_part = acc_q[2*W-1:W-1];
    div_diff = {1'b0, div_part} - {2'b0, a_q};
    div_nxt  = div_diff[W+1] ? {div_part[W-1:0], acc_q[W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
    prod     = neg_res_q ? ((2*W)'(0) - mul_nxt) : mul_nxt;
    quo      = neg_res_q ? (W'(0) - div_nxt[W-1:0]) : div_nxt[W-1:0];
    // Zero divisor leaves rem = |dividend|; restoring its sign yields operand_1 unchanged.
    rem      = neg_rem_q ? (W'(0) - div_nxt[2*W-1:W]) : div_nxt[2*W-1:W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    if (en && is_mul) state_d = MUL;
                 else if (en && is_div) state_d = DIV;
        MUL,
        DIV:     if (last) state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: if (en && !flush) begin
        if (is_mul || is_div) begin
          cnt_d     = '0;
          acc_d     = {{W{1'b0}}, is_mul ? op2_abs : op1_abs};
          a_d       = is_mul ? op1_abs : op2_abs;
          neg_res_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
        end
        if (funct == F_MTHI) hi_d = operand_1;
        if (funct == F_MTLO) lo_d = operand_1;
      end
      MUL: begin
        acc_d = mul_nxt;
        cnt_d = cnt_q + CW'(1);
        // Results land on the edge into DONE so they are visible alongside done.
        if (last && !flush) {hi_d, lo_d} = prod;
      end
      DIV: begin
        acc_d = div_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last && !flush) begin
          hi_d = rem;
          lo_d = (a_q == '0) ? '1 : quo;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_req = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE:    stall_req = en && (is_mul || is_div) && !flush;
      MUL,
      DIV:     stall_req = !flush;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign hi = hi_q;
  assign lo = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO pushed at issue, popped when done pulses.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, flush = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] operand_1 = '0, operand_2 = '0;
  logic        stall_req, done;
  logic [31:0] hi, lo;

  int tests = 0, fails = 0;
  logic [63:0] sb_q[$];

  ex_muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .funct(funct),
    .operand_1(operand_1), .operand_2(operand_2),
    .stall_req(stall_req), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sb;
    int     ia, ib, q, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ia = $signed(a); ib = $signed(b);
    case (f)
      6'h18: model = 64'(sa * sb);
      6'h19: model = {32'b0, a} * {32'b0, b};
      6'h1A: if (b == 0) model = {a, 32'hFFFF_FFFF};
             else begin q = ia / ib; r = ia % ib; model = {32'(r), 32'(q)}; end
      default: if (b == 0) model = {a, 32'hFFFF_FFFF};
               else model = {a % b, a / b};
    endcase
  endfunction

  // Drives one mul/div and waits for done; optional MTHI noise while busy must be ignored.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit noise, output int edges, output int stalls,
                       output logic stall_at_done, output logic [31:0] h, output logic [31:0] l);
    @(negedge clk);
    en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
    #1 stalls = stall_req ? 1 : 0;
    @(negedge clk);
    edges = 1;
    if (noise) begin funct = 6'h11; operand_1 = 32'hDEAD_BEEF; end else en = 1'b0;
    while (!done && edges < 100) begin
      if (stall_req) stalls++;
      @(negedge clk);
      edges++;
    end
    en = 1'b0;
    stall_at_done = stall_req;
    h = hi; l = lo;
    @(negedge clk);
  endtask

  task automatic check_op(input string nm, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input bit noise);
    int edges, stalls;
    logic sad;
    logic [31:0] h, l;
    logic [63:0] e;
    sb_q.push_back(exp);
    issue(f, a, b, noise, edges, stalls, sad, h, l);
    e = sb_q.pop_front();
    tests++;
    if (edges !== 33) begin fails++; $display("FAIL %s latency: got %0d want 33", nm, edges); end
    tests++;
    if (stalls !== 33) begin fails++; $display("FAIL %s stall_cycles: got %0d want 33", nm, stalls); end
    tests++;
    if (sad !== 1'b0) begin fails++; $display("FAIL %s stall_in_done: got %b want 0", nm, sad); end
    tests++;
    if ({h, l} !== e) begin fails++; $display("FAIL %s hilo: got %h_%h want %h_%h", nm, h, l, e[63:32], e[31:0]); end
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if ({hi, lo, done, stall_req} !== 66'b0) begin
      fails++; $display("FAIL reset: got hi=%h lo=%h done=%b stall=%b want zeros", hi, lo, done, stall_req);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    check_op("multu_max", 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    check_op("mult_neg",  6'h18, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, 0);
    check_op("mult_min",  6'h18, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
  endtask

  task automatic test_div;
    check_op("div_neg_dvd", 6'h1A, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 0);
    check_op("divu_7_2",    6'h1B, 32'd7,         32'd2,         64'h0000_0001_0000_0003, 0);
    check_op("div_neg_dvs", 6'h1A, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0);
  endtask

  task automatic test_div_zero;
    check_op("divu_zero", 6'h1B, 32'h1234,      32'd0, 64'h0000_1234_FFFF_FFFF, 0);
    check_op("div_zero",  6'h1A, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, 0);
  endtask

  task automatic test_mthi_mtlo;
    @(negedge clk); en = 1'b1; funct = 6'h11; operand_1 = 32'h1234;
    #1 tests++;
    if (stall_req !== 1'b0) begin fails++; $display("FAIL mthi_stall: got %b want 0", stall_req); end
    @(negedge clk); funct = 6'h13; operand_1 = 32'h5678;
    tests++;
    if (hi !== 32'h1234) begin fails++; $display("FAIL mthi: got %h want 00001234", hi); end
    @(negedge clk); funct = 6'h11; operand_1 = 32'hFFFF; flush = 1'b1;
    tests++;
    if (lo !== 32'h5678 || done !== 1'b0) begin
      fails++; $display("FAIL mtlo: got lo=%h done=%b want 00005678 0", lo, done);
    end
    @(negedge clk); en = 1'b0; flush = 1'b0;
    tests++;
    if (hi !== 32'h1234) begin fails++; $display("FAIL mthi_flush: got %h want 00001234", hi); end
  endtask

  task automatic test_flush;
    int pulses = 0;
    @(negedge clk); en = 1'b1; funct = 6'h11; operand_1 = 32'hA5;
    @(negedge clk); funct = 6'h13;
    @(negedge clk); funct = 6'h1A; operand_1 = 32'd1000; operand_2 = 32'd3;
    @(negedge clk); en = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1 tests++;
    if (stall_req !== 1'b0) begin fails++; $display("FAIL flush_stall: got %b want 0", stall_req); end
    @(negedge clk); flush = 1'b0;
    tests++;
    if (stall_req !== 1'b0) begin fails++; $display("FAIL flush_idle: got stall=%b want 0", stall_req); end
    repeat (40) begin @(negedge clk); if (done) pulses++; end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL flush_done: got %0d pulses want 0", pulses); end
    tests++;
    if (hi !== 32'hA5 || lo !== 32'hA5) begin fails++; $display("FAIL flush_hilo: got %h_%h want a5_a5", hi, lo); end
  endtask

  task automatic test_busy_ignore;
    check_op("busy_ignore", 6'h19, 32'd3, 32'd4, 64'd12, 1);
  endtask

  task automatic test_back_to_back;
    logic [5:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      f = 6'h18 + 6'(i % 4);
      a = $urandom; b = (i == 6) ? 32'd0 : $urandom >> (i % 3) * 8;
      if (a == 32'h8000_0000) a = 32'h7FFF_FFFF;
      check_op($sformatf("rand%0d", i), f, a, b, model(f, a, b), 0);
    end
  endtask

  task automatic test_reset_mid_op;
    int pulses = 0;
    @(negedge clk); en = 1'b1; funct = 6'h19; operand_1 = 32'hFFFF_FFFF; operand_2 = 32'hFFFF_FFFF;
    @(negedge clk); en = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1 tests++;
    if ({hi, lo, done, stall_req} !== 66'b0) begin
      fails++; $display("FAIL reset_mid: got hi=%h lo=%h done=%b stall=%b want zeros", hi, lo, done, stall_req);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin @(negedge clk); if (done || stall_req) pulses++; end
    tests++;
    if (pulses !== 0 || hi !== 32'h0) begin
      fails++; $display("FAIL reset_mid_idle: got activity=%0d hi=%h want 0 0", pulses, hi);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_div;
    test_div_zero;
    test_mthi_mtlo;
    test_flush;
    test_busy_ignore;
    test_back_to_back;
    test_reset_mid_op;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
